// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between decode/EX/MEM hazard sources and the pipeline stall controller.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             data_hazard;
    logic             call;
    logic             ret;
    logic             branch;
    logic             branch_resolved;
    logic             branch_taken;
    logic             call_target_vld;
    logic             ret_addr_vld;
    logic             stall_pc;
    logic             stall_ifid;
    logic             flush_ifid;
    logic             bubble_idex;
    logic [1:0]       pc_sel;
    logic             clr_call_haz;
    logic             clr_ret_haz;
    logic             clr_branch_haz;
    logic             ctrl_timeout;
    logic [CNT_W-1:0] data_stall_cnt;
    logic [CNT_W-1:0] ctrl_stall_cnt;

    modport master (
        output data_hazard, call, ret, branch, branch_resolved, branch_taken,
               call_target_vld, ret_addr_vld,
        input  stall_pc, stall_ifid, flush_ifid, bubble_idex, pc_sel, clr_call_haz,
               clr_ret_haz, clr_branch_haz, ctrl_timeout, data_stall_cnt, ctrl_stall_cnt
    );

    modport slave (
        input  data_hazard, call, ret, branch, branch_resolved, branch_taken,
               call_target_vld, ret_addr_vld,
        output stall_pc, stall_ifid, flush_ifid, bubble_idex, pc_sel, clr_call_haz,
               clr_ret_haz, clr_branch_haz, ctrl_timeout, data_stall_cnt, ctrl_stall_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush sequencer for data hazards and call/ret/branch resolution.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CNT_W    = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_stall_ctrl_if.slave bus_io
);
    localparam int unsigned     WcW    = $clog2(MAX_WAIT);
    localparam logic [WcW-1:0]  WcLast = WcW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {StRun, StBrWait, StCallWait, StRetWait} state_e;

    state_e         state_q, state_d;
    logic [WcW-1:0] wcnt_q, wcnt_d;
    logic           timeout_q, timeout_d;
    logic           in_wait, resolved, expire;

    assign in_wait  = (state_q != StRun);
    assign resolved = ((state_q == StBrWait)   && bus_io.branch_resolved) ||
                      ((state_q == StCallWait) && bus_io.call_target_vld) ||
                      ((state_q == StRetWait)  && bus_io.ret_addr_vld);
    assign expire   = in_wait && !resolved && (wcnt_q == WcLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = in_wait ? wcnt_q + WcW'(1) : '0;
        timeout_d = timeout_q | expire;
        unique case (state_q)
            StRun: begin
                if (!bus_io.data_hazard) begin
                    if (bus_io.call)        state_d = StCallWait;
                    else if (bus_io.ret)    state_d = StRetWait;
                    else if (bus_io.branch) state_d = StBrWait;
                end
            end
            default: begin
                if (resolved || expire) state_d = StRun;
            end
        endcase
    end

    // Outputs are forced low while rst is held, regardless of the Mealy inputs.
    always_comb begin
        bus_io.stall_pc       = 1'b0;
        bus_io.stall_ifid     = 1'b0;
        bus_io.flush_ifid     = 1'b0;
        bus_io.bubble_idex    = 1'b0;
        bus_io.pc_sel         = 2'b00;
        bus_io.clr_call_haz   = 1'b0;
        bus_io.clr_ret_haz    = 1'b0;
        bus_io.clr_branch_haz = 1'b0;
        bus_io.ctrl_timeout   = timeout_q & ~rst;
        if (!rst) begin
            if (state_q == StRun) begin
                if (bus_io.data_hazard) begin
                    bus_io.stall_pc    = 1'b1;
                    bus_io.stall_ifid  = 1'b1;
                    bus_io.bubble_idex = 1'b1;
                end else if (bus_io.call || bus_io.ret || bus_io.branch) begin
                    bus_io.stall_pc   = 1'b1;
                    bus_io.flush_ifid = 1'b1;
                end
            end else if (resolved || expire) begin
                unique case (state_q)
                    StBrWait: begin
                        bus_io.clr_branch_haz = 1'b1;
                        if (resolved && bus_io.branch_taken) bus_io.pc_sel = 2'b01;
                    end
                    StCallWait: begin
                        bus_io.clr_call_haz = 1'b1;
                        if (resolved) bus_io.pc_sel = 2'b01;
                    end
                    default: begin
                        bus_io.clr_ret_haz = 1'b1;
                        if (resolved) bus_io.pc_sel = 2'b10;
                    end
                endcase
            end else begin
                bus_io.stall_pc   = 1'b1;
                bus_io.flush_ifid = 1'b1;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] dcnt_q, dcnt_d, ccnt_q, ccnt_d;

    always_comb begin
        dcnt_d = dcnt_q;
        ccnt_d = ccnt_q;
        if (!in_wait && bus_io.data_hazard && (dcnt_q != '1)) dcnt_d = dcnt_q + CNT_W'(1);
        if (in_wait && (ccnt_q != '1))                        ccnt_d = ccnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_q <= '0;
            ccnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
            ccnt_q <= ccnt_d;
        end
    end

    assign bus_io.data_stall_cnt = dcnt_q;
    assign bus_io.ctrl_stall_cnt = ccnt_q;
`else
    assign bus_io.data_stall_cnt = {CNT_W{1'b0}};
    assign bus_io.ctrl_stall_cnt = {CNT_W{1'b0}};
`endif
endmodule
